// File: rtl/guess_pkg.sv
// Shared state encodings and key codes for the Bulls-and-Cows game core
// and its scoring sub-module.
package guess_pkg;

  typedef enum logic [2:0] {
    ST_SET_SECRET = 3'd0,
    ST_GUESS      = 3'd1,
    ST_CHECK      = 3'd2,
    ST_SHOW       = 3'd3,
    ST_WIN        = 3'd4,
    ST_LOSE       = 3'd5
  } game_state_e;

  localparam logic [3:0] KEY_BKSP  = 4'hA;
  localparam logic [3:0] KEY_ENTER = 4'hB;
  localparam logic [3:0] KEY_CLEAR = 4'hC;
  localparam logic [3:0] KEY_NEW   = 4'hF;

  function automatic logic is_digit(input logic [3:0] code);
    return (code <= 4'd9);
  endfunction

endpackage

// File: rtl/bulls_cows_score.sv
// Registered A/B scorer: A counts exact position matches, B counts right digits
// in the wrong place (multiset rule when repeated digits are allowed).
module bulls_cows_score
  import guess_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int ALLOW_REPEAT = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [4*NUM_DIGITS-1:0] secret,
  input  logic [4*NUM_DIGITS-1:0] guess,
  output logic [3:0]              a,
  output logic [3:0]              b
);

  logic [3:0] a_s;
  logic [3:0] b_s;
  logic [3:0] a_r;
  logic [3:0] b_r;

  // Combinational A/B score of the current guess against the secret
  always_comb begin
    logic [3:0] total;
    logic [3:0] cnt_s;
    logic [3:0] cnt_g;
    logic       hit;
    a_s   = 4'd0;
    b_s   = 4'd0;
    total = 4'd0;
    cnt_s = 4'd0;
    cnt_g = 4'd0;
    hit   = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      a_s = a_s + ((secret[i*4 +: 4] == guess[i*4 +: 4]) ? 4'd1 : 4'd0);
    end
    if (ALLOW_REPEAT != 0) begin
      // Common digits as a multiset, then remove the exact hits
      for (int v = 0; v < 10; v++) begin
        cnt_s = 4'd0;
        cnt_g = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
          cnt_s = cnt_s + ((secret[i*4 +: 4] == 4'(v)) ? 4'd1 : 4'd0);
          cnt_g = cnt_g + ((guess[i*4 +: 4] == 4'(v)) ? 4'd1 : 4'd0);
        end
        total = total + ((cnt_s < cnt_g) ? cnt_s : cnt_g);
      end
      b_s = total - a_s;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        hit = 1'b0;
        for (int j = 0; j < NUM_DIGITS; j++) begin
          hit = hit | ((i != j) && (secret[j*4 +: 4] == guess[i*4 +: 4]));
        end
        b_s = b_s + {3'd0, hit};
      end
    end
  end

  // Score register, loaded during the CHECK cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r <= 4'd0;
      b_r <= 4'd0;
    end else if (en) begin
      a_r <= a_s;
      b_r <= b_s;
    end else begin
      a_r <= a_r;
      b_r <= b_r;
    end
  end

  assign a = a_r;
  assign b = b_r;

endmodule

// File: rtl/guess_game_core.sv
// Bulls-and-Cows game engine: keypad entry editing, secret/guess buffers,
// attempt counting and win/lose decision around the registered scorer.
module guess_game_core
  import guess_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int MAX_TRIES    = 10,
  parameter int ALLOW_REPEAT = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    key_valid,
  input  logic [3:0]              key_code,
  output logic [2:0]              game_state,
  output logic [4*NUM_DIGITS-1:0] entry_flat,
  output logic [3:0]              entry_len,
  output logic [3:0]              cnt_a,
  output logic [3:0]              cnt_b,
  output logic [3:0]              tries,
  output logic                    result_valid,
  output logic                    key_err,
  output logic [4*NUM_DIGITS-1:0] secret_flat
);

  localparam int W = 4 * NUM_DIGITS;

  game_state_e  state_r,  state_nxt_s;
  logic [W-1:0] entry_r,  entry_nxt_s;
  logic [3:0]   len_r,    len_nxt_s;
  logic [W-1:0] secret_r, secret_nxt_s;
  logic [W-1:0] sflat_r,  sflat_nxt_s;
  logic [3:0]   cnt_a_r,  cnt_a_nxt_s;
  logic [3:0]   cnt_b_r,  cnt_b_nxt_s;
  logic [3:0]   tries_r,  tries_nxt_s;
  logic         rv_r,     rv_nxt_s;
  logic         kerr_r,   kerr_nxt_s;
  logic         new_game_s;
  logic         dup_s;
  logic         full_s;
  logic [3:0]   len_m1_s;
  logic [3:0]   tries_inc_s;
  logic [3:0]   score_a_s;
  logic [3:0]   score_b_s;

  bulls_cows_score #(
    .NUM_DIGITS  (NUM_DIGITS),
    .ALLOW_REPEAT(ALLOW_REPEAT)
  ) u_score (
    .clk   (clk),
    .rst   (rst),
    .en    (state_r == ST_CHECK),
    .secret(secret_r),
    .guess (entry_r),
    .a     (score_a_s),
    .b     (score_b_s)
  );

  assign full_s      = (len_r == 4'(NUM_DIGITS));
  assign len_m1_s    = len_r - 4'd1;
  assign tries_inc_s = (tries_r == 4'd15) ? 4'd15 : (tries_r + 4'd1);

  // Flags a digit key whose value is already present in the entry
  always_comb begin
    dup_s = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      dup_s = dup_s | ((4'(i) < len_r) && (entry_r[i*4 +: 4] == key_code));
    end
  end

  // Next-state and next-output logic for the game FSM
  always_comb begin
    state_nxt_s  = state_r;
    entry_nxt_s  = entry_r;
    len_nxt_s    = len_r;
    secret_nxt_s = secret_r;
    sflat_nxt_s  = sflat_r;
    cnt_a_nxt_s  = cnt_a_r;
    cnt_b_nxt_s  = cnt_b_r;
    tries_nxt_s  = tries_r;
    rv_nxt_s     = 1'b0;
    kerr_nxt_s   = 1'b0;
    new_game_s   = 1'b0;
    case (state_r)
      ST_SET_SECRET, ST_GUESS: begin
        if (!key_valid) begin
          state_nxt_s = state_r;
        end else if (key_code == KEY_NEW) begin
          new_game_s = 1'b1;
        end else if (is_digit(key_code)) begin
          if (full_s || ((ALLOW_REPEAT == 0) && dup_s)) begin
            kerr_nxt_s = 1'b1;
          end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
              entry_nxt_s[i*4 +: 4] = (4'(i) == len_r) ? key_code : entry_r[i*4 +: 4];
            end
            len_nxt_s = len_r + 4'd1;
          end
        end else if (key_code == KEY_BKSP) begin
          if (len_r == 4'd0) begin
            kerr_nxt_s = 1'b1;
          end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
              entry_nxt_s[i*4 +: 4] = (4'(i) == len_m1_s) ? 4'd0 : entry_r[i*4 +: 4];
            end
            len_nxt_s = len_m1_s;
          end
        end else if (key_code == KEY_CLEAR) begin
          entry_nxt_s = '0;
          len_nxt_s   = 4'd0;
        end else if (key_code == KEY_ENTER) begin
          if (!full_s) begin
            kerr_nxt_s = 1'b1;
          end else if (state_r == ST_SET_SECRET) begin
            secret_nxt_s = entry_r;
            entry_nxt_s  = '0;
            len_nxt_s    = 4'd0;
            state_nxt_s  = ST_GUESS;
          end else begin
            state_nxt_s = ST_CHECK;
          end
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_CHECK: begin
        state_nxt_s = ST_SHOW;
      end
      ST_SHOW: begin
        cnt_a_nxt_s = score_a_s;
        cnt_b_nxt_s = score_b_s;
        rv_nxt_s    = 1'b1;
        tries_nxt_s = tries_inc_s;
        // A win on the last allowed attempt still counts as a win
        if (score_a_s == 4'(NUM_DIGITS)) begin
          state_nxt_s = ST_WIN;
        end else if (tries_inc_s == 4'(MAX_TRIES)) begin
          state_nxt_s = ST_LOSE;
          sflat_nxt_s = secret_r;
        end else begin
          state_nxt_s = ST_GUESS;
          entry_nxt_s = '0;
          len_nxt_s   = 4'd0;
        end
      end
      ST_WIN, ST_LOSE: begin
        if (!key_valid) begin
          state_nxt_s = state_r;
        end else if (key_code == KEY_NEW) begin
          new_game_s = 1'b1;
        end else begin
          kerr_nxt_s = 1'b1;
        end
      end
      default: begin
        state_nxt_s = ST_SET_SECRET;
      end
    endcase
  end

  // State and output registers; new game behaves exactly like reset
  always_ff @(posedge clk) begin
    if (rst || new_game_s) begin
      state_r  <= ST_SET_SECRET;
      entry_r  <= '0;
      len_r    <= 4'd0;
      secret_r <= '0;
      sflat_r  <= '0;
      cnt_a_r  <= 4'd0;
      cnt_b_r  <= 4'd0;
      tries_r  <= 4'd0;
      rv_r     <= 1'b0;
      kerr_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      entry_r  <= entry_nxt_s;
      len_r    <= len_nxt_s;
      secret_r <= secret_nxt_s;
      sflat_r  <= sflat_nxt_s;
      cnt_a_r  <= cnt_a_nxt_s;
      cnt_b_r  <= cnt_b_nxt_s;
      tries_r  <= tries_nxt_s;
      rv_r     <= rv_nxt_s;
      kerr_r   <= kerr_nxt_s;
    end
  end

  assign game_state   = state_r;
  assign entry_flat   = entry_r;
  assign entry_len    = len_r;
  assign cnt_a        = cnt_a_r;
  assign cnt_b        = cnt_b_r;
  assign tries        = tries_r;
  assign result_valid = rv_r;
  assign key_err      = kerr_r;
  assign secret_flat  = sflat_r;

endmodule
